axi_line_responder: RTL and testbench
=====================================

Name: axi_line_responder

Overview:
- Simplified AXI4 memory responder (subordinate) that serves the dcache's line-refill and writeback bursts and its single-beat bypass accesses.
- Sits at the far end of the cache's data and bypass AXI ports in block-level and subsystem benches. Also usable as a small on-chip scratch memory.
- Independent read and write channel FSMs operate on a shared word-addressed memory array.

Parameters:
- AddrWidth, 64, byte-address width on AR/AW
- DataWidth, 64, beat width in bits; power of two, at least 32
- IdWidth, 4, transaction ID width
- NumWords, 1024, memory depth in DataWidth words; power of two
- ReadLatency, 2, cycles from AR handshake to the first R beat being valid; range 1..15

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- ar_valid_i  in  1  read address valid
- ar_ready_o  out  1  read address ready
- ar_addr_i  in  AddrWidth  read start byte address
- ar_len_i  in  8  read beats minus one
- ar_id_i  in  IdWidth  read ID
- r_valid_o  out  1  read data valid
- r_ready_i  in  1  read data ready
- r_data_o  out  DataWidth  read data
- r_id_o  out  IdWidth  read ID echo
- r_last_o  out  1  last read beat
- r_resp_o  out  2  read response; 00 OKAY, 11 DECERR
- aw_valid_i  in  1  write address valid
- aw_ready_o  out  1  write address ready
- aw_addr_i  in  AddrWidth  write start byte address
- aw_len_i  in  8  write beats minus one
- aw_id_i  in  IdWidth  write ID
- w_valid_i  in  1  write data valid
- w_ready_o  out  1  write data ready
- w_data_i  in  DataWidth  write data
- w_strb_i  in  DataWidth/8  byte strobes
- w_last_i  in  1  last write beat
- b_valid_o  out  1  write response valid
- b_ready_i  in  1  write response ready
- b_id_o  out  IdWidth  write ID echo
- b_resp_o  out  2  write response

Behaviour:
- Single clock domain. All state is reset synchronously when rst_i=1; the memory array is not cleared.
- Output values during and after reset:
  - ar_ready_o=1, aw_ready_o=1.
  - r_valid_o=0, w_ready_o=0, b_valid_o=0.
  - r_last_o=0, r_resp_o=0, b_resp_o=0, r_id_o=0, b_id_o=0, r_data_o=0.
- Burst type is always INCR and beat size is always full DataWidth. Low address bits below log2(DataWidth/8) are ignored.
- Word index = (addr >> log2(DataWidth/8)) mod NumWords. Each beat increments the index by 1, and the index wraps from NumWords-1 to 0.
- Read FSM:
  - R_IDLE: ar_ready_o=1. On ar_valid_i, latch id, len and index; load the latency counter with ReadLatency-1; go to R_WAIT. If ReadLatency=1, go directly to R_BURST.
  - R_WAIT: decrement the counter; at 0 go to R_BURST.
  - R_BURST: r_valid_o=1; r_data_o=mem[index]; r_last_o=1 when the beat count equals len. On r_ready_i, advance the index and beat count. On the last-beat handshake, return to R_IDLE; AR is accepted again in the following cycle.
  - r_data_o, r_id_o, r_last_o and r_resp_o stay stable while r_valid_o=1 and r_ready_i=0.
- Write FSM:
  - W_IDLE: aw_ready_o=1. On aw_valid_i, latch id, len and index; go to W_DATA.
  - W_DATA: w_ready_o=1. Each w handshake writes the bytes enabled by w_strb_i into mem[index] at the clock edge, then advances the index.
  - The last beat is defined by the beat count reaching len. If w_last_i disagrees with the beat count, the last beat is still written and b_resp_o=10 (SLVERR); otherwise 00. On the last beat, go to W_RESP.
  - W_RESP: b_valid_o=1 until b_ready_i; then go to W_IDLE.
  - W beats presented before the AW handshake are not accepted, because w_ready_o=0 outside W_DATA.
- Concurrency: the read and write FSMs run independently. If a read and a write target the same word in the same cycle, the read returns the old data. A write is visible to any beat presented from the next cycle onward.
- One outstanding transaction per direction. There is no ID reordering.
- rst_i asserted mid-burst aborts both FSMs to IDLE in the next cycle, with no response issued.

Optional Feature:
- Macro: AXI_LINE_RESPONDER_DECERR_EN.
- When defined: a burst whose start byte address is at or above NumWords*DataWidth/8 is flagged at AR/AW acceptance.
  - Flagged read: every R beat has r_resp_o=11 and r_data_o=0.
  - Flagged write: every W beat is accepted but the memory is left unmodified, and b_resp_o=11.
- When undefined: addresses alias modulo NumWords and all responses are OKAY, apart from the SLVERR w_last mismatch case.

Test Plan:
- Reset then idle: after rst_i, ar_ready_o=1, aw_ready_o=1, and r_valid_o, w_ready_o and b_valid_o are all 0.
- Write then read: AW addr 0x40, len 7, data beats 0x1000..0x1007 with full strobes, yielding b_resp 00. Then AR 0x40, len 7 (ReadLatency=2): the first r_valid_o appears 2 cycles after the AR handshake, returning 0x1000..0x1007 with r_last_o only on beat 8.
- Strobes: write 0xFFFFFFFFFFFFFFFF to 0x0. Then write 0x0 with strb 0x0F. A read of 0x0 returns 0xFFFFFFFF00000000.
- Backpressure and wrap: AR index NumWords-2, len 3, r_ready_i toggled 1,0,0,1,... Beats come from indices 1022, 1023, 0, 1 (NumWords=1024), and outputs stay stable while stalled.
- w_last mismatch: aw_len 3 with w_last_i asserted on beat 2. All 4 beats are written and b_resp_o=10.
- With AXI_LINE_RESPONDER_DECERR_EN: AR addr NumWords*8, len 1 returns 2 beats with r_resp_o=11 and r_data_o=0. Mid-burst rst_i drops r_valid_o the next cycle.

Source files
------------

// File: rtl/axi_line_responder.sv
// axi_line_responder: simplified AXI4 subordinate memory for dcache refill,
// writeback and bypass traffic. Independent read and write channel FSMs share
// one word-addressed array. INCR bursts only, full-width beats.
// Optional out-of-range DECERR checking is enabled by defining
// AXI_LINE_RESPONDER_DECERR_EN; without it addresses alias modulo NumWords.
module axi_line_responder #(
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned IdWidth     = 4,
    parameter int unsigned NumWords    = 1024,
    parameter int unsigned ReadLatency = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   ar_valid_i,
    output logic                   ar_ready_o,
    input  logic [AddrWidth-1:0]   ar_addr_i,
    input  logic [7:0]             ar_len_i,
    input  logic [IdWidth-1:0]     ar_id_i,
    output logic                   r_valid_o,
    input  logic                   r_ready_i,
    output logic [DataWidth-1:0]   r_data_o,
    output logic [IdWidth-1:0]     r_id_o,
    output logic                   r_last_o,
    output logic [1:0]             r_resp_o,
    input  logic                   aw_valid_i,
    output logic                   aw_ready_o,
    input  logic [AddrWidth-1:0]   aw_addr_i,
    input  logic [7:0]             aw_len_i,
    input  logic [IdWidth-1:0]     aw_id_i,
    input  logic                   w_valid_i,
    output logic                   w_ready_o,
    input  logic [DataWidth-1:0]   w_data_i,
    input  logic [DataWidth/8-1:0] w_strb_i,
    input  logic                   w_last_i,
    output logic                   b_valid_o,
    input  logic                   b_ready_i,
    output logic [IdWidth-1:0]     b_id_o,
    output logic [1:0]             b_resp_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned OffW      = $clog2(StrbWidth);
    localparam int unsigned IdxW      = $clog2(NumWords);
    localparam logic [3:0]  LatInit   = 4'(ReadLatency - 1);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}  w_state_e;

    logic [DataWidth-1:0] mem [NumWords];

    // Read channel state
    r_state_e            r_state_q, r_state_d;
    logic [IdxW-1:0]     r_idx_q, r_idx_d;
    logic [7:0]          r_cnt_q, r_cnt_d;
    logic [7:0]          r_len_q, r_len_d;
    logic [IdWidth-1:0]  r_id_q, r_id_d;
    logic                r_oob_q, r_oob_d;
    logic [3:0]          lat_q, lat_d;

    // Write channel state
    w_state_e            w_state_q, w_state_d;
    logic [IdxW-1:0]     w_idx_q, w_idx_d;
    logic [7:0]          w_cnt_q, w_cnt_d;
    logic [7:0]          w_len_q, w_len_d;
    logic [IdWidth-1:0]  w_id_q, w_id_d;
    logic                w_oob_q, w_oob_d;
    logic                w_err_q, w_err_d;
    logic [1:0]          b_resp_q, b_resp_d;

    logic [IdxW-1:0] ar_idx, aw_idx;
    logic            ar_oob, aw_oob;
    logic            r_beat_last, w_beat_last, w_last_bad, w_hs;

    assign ar_idx = ar_addr_i[OffW +: IdxW];
    assign aw_idx = aw_addr_i[OffW +: IdxW];

`ifdef AXI_LINE_RESPONDER_DECERR_EN
    localparam logic [AddrWidth:0] MemBytes = (AddrWidth + 1)'(NumWords) << OffW;
    assign ar_oob = {1'b0, ar_addr_i} >= MemBytes;
    assign aw_oob = {1'b0, aw_addr_i} >= MemBytes;
`else
    assign ar_oob = 1'b0;
    assign aw_oob = 1'b0;
`endif

    // Only the word-index field of the addresses addresses memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ar_addr_i, aw_addr_i};

    assign r_beat_last = (r_cnt_q == r_len_q);
    assign w_beat_last = (w_cnt_q == w_len_q);
    assign w_last_bad  = (w_last_i != w_beat_last);
    assign w_hs        = (w_state_q == W_DATA) && w_valid_i;

    // Read FSM next-state: address latch, latency countdown, beat sequencing
    always_comb begin
        // NOTE: every _d gets its current value first so no path can infer a latch.
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_cnt_d   = r_cnt_q;
        r_len_d   = r_len_q;
        r_id_d    = r_id_q;
        r_oob_d   = r_oob_q;
        lat_d     = lat_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_valid_i) begin
                    r_idx_d   = ar_idx;
                    r_cnt_d   = 8'd0;
                    r_len_d   = ar_len_i;
                    r_id_d    = ar_id_i;
                    r_oob_d   = ar_oob;
                    lat_d     = LatInit;
                    r_state_d = (ReadLatency == 1) ? R_BURST : R_WAIT;
                end
            end
            R_WAIT: begin
                lat_d = lat_q - 4'd1;
                if (lat_q <= 4'd1) begin
                    r_state_d = R_BURST;
                end
            end
            R_BURST: begin
                if (r_ready_i) begin
                    r_idx_d = r_idx_q + IdxW'(1);
                    r_cnt_d = r_cnt_q + 8'd1;
                    if (r_beat_last) begin
                        r_state_d = R_IDLE;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read channel registers
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst_i) begin
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_cnt_q   <= '0;
            r_len_q   <= '0;
            r_id_q    <= '0;
            r_oob_q   <= 1'b0;
            lat_q     <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_cnt_q   <= r_cnt_d;
            r_len_q   <= r_len_d;
            r_id_q    <= r_id_d;
            r_oob_q   <= r_oob_d;
            lat_q     <= lat_d;
        end
    end

    // Write FSM next-state: address latch, beat counting, response selection
    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_cnt_d   = w_cnt_q;
        w_len_d   = w_len_q;
        w_id_d    = w_id_q;
        w_oob_d   = w_oob_q;
        w_err_d   = w_err_q;
        b_resp_d  = b_resp_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_valid_i) begin
                    w_idx_d   = aw_idx;
                    w_cnt_d   = 8'd0;
                    w_len_d   = aw_len_i;
                    w_id_d    = aw_id_i;
                    w_oob_d   = aw_oob;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_valid_i) begin
                    w_idx_d = w_idx_q + IdxW'(1);
                    w_cnt_d = w_cnt_q + 8'd1;
                    w_err_d = w_err_q | w_last_bad;
                    if (w_beat_last) begin
                        // Beat count, not w_last_i, closes the burst.
                        if (w_oob_q) begin
                            b_resp_d = RespDecErr;
                        end else if (w_err_q || w_last_bad) begin
                            b_resp_d = RespSlvErr;
                        end else begin
                            b_resp_d = RespOkay;
                        end
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (b_ready_i) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write channel registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_cnt_q   <= '0;
            w_len_q   <= '0;
            w_id_q    <= '0;
            w_oob_q   <= 1'b0;
            w_err_q   <= 1'b0;
            b_resp_q  <= RespOkay;
        end else begin
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_cnt_q   <= w_cnt_d;
            w_len_q   <= w_len_d;
            w_id_q    <= w_id_d;
            w_oob_q   <= w_oob_d;
            w_err_q   <= w_err_d;
            b_resp_q  <= b_resp_d;
        end
    end

    // Byte-masked memory write on each accepted W beat
    always_ff @(posedge clk_i) begin
        // NOTE: the array has no reset; its contents persist across rst_i by design.
        if (!rst_i && w_hs && !w_oob_q) begin
            for (int b = 0; b < int'(StrbWidth); b++) begin
                if (w_strb_i[b]) begin
                    mem[w_idx_q][8*b +: 8] <= w_data_i[8*b +: 8];
                end
            end
        end
    end

    // Read data is an asynchronous array read, so a write lands on the next
    // presented beat while a same-cycle read still sees the old word.
    assign ar_ready_o = (r_state_q == R_IDLE);
    assign r_valid_o  = (r_state_q == R_BURST);
    assign r_data_o   = (r_valid_o && !r_oob_q) ? mem[r_idx_q] : '0;
    assign r_id_o     = r_valid_o ? r_id_q : '0;
    assign r_last_o   = r_valid_o && r_beat_last;
    assign r_resp_o   = (r_valid_o && r_oob_q) ? RespDecErr : RespOkay;

    assign aw_ready_o = (w_state_q == W_IDLE);
    assign w_ready_o  = (w_state_q == W_DATA);
    assign b_valid_o  = (w_state_q == W_RESP);
    assign b_id_o     = b_valid_o ? w_id_q : '0;
    assign b_resp_o   = b_valid_o ? b_resp_q : RespOkay;

endmodule

// File: tb/tb_axi_line_responder.sv
// Self-checking bench for axi_line_responder with a word-array reference model.
module tb_axi_line_responder;

    localparam int NW  = 1024;
    localparam int RL  = 2;
    localparam logic [63:0] MEM_BYTES = 64'(NW * 8);
`ifdef AXI_LINE_RESPONDER_DECERR_EN
    localparam bit DECERR_EN = 1'b1;
`else
    localparam bit DECERR_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        ar_valid_i = 1'b0;
    logic        ar_ready_o;
    logic [63:0] ar_addr_i = '0;
    logic [7:0]  ar_len_i = '0;
    logic [3:0]  ar_id_i = '0;
    logic        r_valid_o;
    logic        r_ready_i = 1'b0;
    logic [63:0] r_data_o;
    logic [3:0]  r_id_o;
    logic        r_last_o;
    logic [1:0]  r_resp_o;
    logic        aw_valid_i = 1'b0;
    logic        aw_ready_o;
    logic [63:0] aw_addr_i = '0;
    logic [7:0]  aw_len_i = '0;
    logic [3:0]  aw_id_i = '0;
    logic        w_valid_i = 1'b0;
    logic        w_ready_o;
    logic [63:0] w_data_i = '0;
    logic [7:0]  w_strb_i = '0;
    logic        w_last_i = 1'b0;
    logic        b_valid_o;
    logic        b_ready_i = 1'b0;
    logic [3:0]  b_id_o;
    logic [1:0]  b_resp_o;

    axi_line_responder #(
        .AddrWidth(64), .DataWidth(64), .IdWidth(4), .NumWords(NW), .ReadLatency(RL)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
        .ar_len_i(ar_len_i), .ar_id_i(ar_id_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o),
        .r_id_o(r_id_o), .r_last_o(r_last_o), .r_resp_o(r_resp_o),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i),
        .aw_len_i(aw_len_i), .aw_id_i(aw_id_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
        .w_strb_i(w_strb_i), .w_last_i(w_last_i),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: memory words plus a "known" flag per word.
    logic [63:0] ref_mem   [NW];
    bit          ref_known [NW];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic bit is_oob(input logic [63:0] addr);
        return DECERR_EN && (addr >= MEM_BYTES);
    endfunction

    // Full AXI write burst; last_pos is the beat on which w_last_i is raised.
    task automatic axi_write(input logic [63:0] addr, input int len, input logic [63:0] data[],
                             input logic [7:0] strb[], input int last_pos);
        int          idx;
        int          k;
        logic [3:0]  id;
        logic [1:0]  exp_resp;
        bit          oob;
        id  = 4'($urandom);
        oob = is_oob(addr);
        idx = int'((addr >> 3) % NW);
        exp_resp = oob ? 2'b11 : ((last_pos != len) ? 2'b10 : 2'b00);
        aw_valid_i = 1'b1; aw_addr_i = addr; aw_len_i = 8'(len); aw_id_i = id;
        for (k = 0; k < 50 && !aw_ready_o; k++) tick();
        check("aw_ready", 64'(aw_ready_o), 64'd1);
        tick();
        aw_valid_i = 1'b0;
        for (int i = 0; i <= len; i++) begin
            w_valid_i = 1'b1; w_data_i = data[i]; w_strb_i = strb[i];
            w_last_i = (i == last_pos);
            for (k = 0; k < 50 && !w_ready_o; k++) tick();
            check("w_ready", 64'(w_ready_o), 64'd1);
            tick();
            if (!oob) begin
                for (int b = 0; b < 8; b++)
                    if (strb[i][b]) ref_mem[idx][8*b +: 8] = data[i][8*b +: 8];
                ref_known[idx] = 1'b1;
            end
            idx = (idx + 1) % NW;
        end
        w_valid_i = 1'b0; w_last_i = 1'b0;
        for (int s = $urandom_range(0, 2); s > 0; s--) begin
            check("b_valid_hold", 64'(b_valid_o), 64'd1);
            tick();
        end
        b_ready_i = 1'b1;
        for (k = 0; k < 50 && !b_valid_o; k++) tick();
        check("b_valid", 64'(b_valid_o), 64'd1);
        check("b_resp", 64'(b_resp_o), 64'(exp_resp));
        check("b_id", 64'(b_id_o), 64'(id));
        tick();
        b_ready_i = 1'b0;
        check("b_valid_drop", 64'(b_valid_o), 64'd0);
        check("aw_ready_back", 64'(aw_ready_o), 64'd1);
    endtask

    // Compare the currently presented R beat against the model.
    task automatic check_beat(input int idx, input bit oob, input bit last, input logic [3:0] id);
        check("r_valid", 64'(r_valid_o), 64'd1);
        if (oob) check("r_data_decerr", r_data_o, 64'd0);
        else if (ref_known[idx]) check("r_data", r_data_o, ref_mem[idx]);
        check("r_last", 64'(r_last_o), 64'(last));
        check("r_resp", 64'(r_resp_o), oob ? 64'd3 : 64'd0);
        check("r_id", 64'(r_id_o), 64'(id));
    endtask

    // Full AXI read burst; mode 0 no stalls, 1 random stalls, 2 ready pattern 1,0,0,1,...
    task automatic axi_read(input logic [63:0] addr, input int len, input int mode);
        int         idx;
        int         k;
        int         lat;
        int         stalls;
        logic [3:0] id;
        bit         oob;
        id  = 4'($urandom);
        oob = is_oob(addr);
        idx = int'((addr >> 3) % NW);
        ar_valid_i = 1'b1; ar_addr_i = addr; ar_len_i = 8'(len); ar_id_i = id;
        for (k = 0; k < 50 && !ar_ready_o; k++) tick();
        check("ar_ready", 64'(ar_ready_o), 64'd1);
        tick();
        ar_valid_i = 1'b0;
        lat = 1;
        for (k = 0; k < 40 && !r_valid_o; k++) begin
            tick();
            lat++;
        end
        check("r_latency", 64'(lat), 64'(RL));
        for (int i = 0; i <= len; i++) begin
            stalls = (mode == 2) ? ((i == 0) ? 0 : 2) : ((mode == 1) ? $urandom_range(0, 2) : 0);
            for (int s = 0; s <= stalls; s++) begin
                r_ready_i = (s == stalls);
                check_beat(idx, oob, i == len, id);
                tick();
            end
            idx = (idx + 1) % NW;
        end
        r_ready_i = 1'b0;
        check("r_valid_drop", 64'(r_valid_o), 64'd0);
        check("ar_ready_back", 64'(ar_ready_o), 64'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ar_ready"}, 64'(ar_ready_o), 64'd1);
        check({tag, "_aw_ready"}, 64'(aw_ready_o), 64'd1);
        check({tag, "_r_valid"},  64'(r_valid_o),  64'd0);
        check({tag, "_w_ready"},  64'(w_ready_o),  64'd0);
        check({tag, "_b_valid"},  64'(b_valid_o),  64'd0);
    endtask

    logic [63:0] wd[];
    logic [7:0]  ws[];

    initial begin
        int          len;
        logic [63:0] addr;

        // Reset then idle; outputs held at their reset values.
        for (int i = 0; i < 3; i++) tick();
        check_idle("reset");
        check("reset_r_data", r_data_o, 64'd0);
        check("reset_r_last", 64'(r_last_o), 64'd0);
        check("reset_b_id", 64'(b_id_o), 64'd0);
        rst_i = 1'b0;
        // W beats are refused before any AW handshake.
        w_valid_i = 1'b1;
        tick();
        check("w_before_aw", 64'(w_ready_o), 64'd0);
        w_valid_i = 1'b0;
        check_idle("post_reset");

        // Write then read a full line at 0x40.
        wd = new[8]; ws = new[8];
        for (int i = 0; i < 8; i++) begin wd[i] = 64'h1000 + 64'(i); ws[i] = 8'hFF; end
        axi_write(64'h40, 7, wd, ws, 7);
        axi_read(64'h40, 7, 0);

        // Partial strobes over a full word.
        wd = new[1]; ws = new[1];
        wd[0] = '1; ws[0] = 8'hFF;
        axi_write(64'h0, 0, wd, ws, 0);
        wd[0] = '0; ws[0] = 8'h0F;
        axi_write(64'h0, 0, wd, ws, 0);
        check("strobe_model", ref_mem[0], 64'hFFFF_FFFF_0000_0000);
        axi_read(64'h0, 0, 0);

        // Index wrap with backpressure.
        wd = new[4]; ws = new[4];
        for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        axi_write(64'((NW - 2) * 8), 3, wd, ws, 3);
        axi_read(64'((NW - 2) * 8), 3, 2);

        // w_last raised early: all beats still written, SLVERR.
        for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        axi_write(64'h200, 3, wd, ws, 2);
        axi_read(64'h200, 3, 1);

        // Randomized bursts across the array.
        for (int t = 0; t < 24; t++) begin
            len  = $urandom_range(0, 7);
            addr = 64'($urandom_range(0, NW - 1)) * 8 + 64'($urandom_range(0, 7));
            wd = new[len + 1]; ws = new[len + 1];
            for (int i = 0; i <= len; i++) begin
                wd[i] = {$urandom, $urandom};
                ws[i] = 8'($urandom);
            end
            axi_write(addr, len, wd, ws, ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : len);
            axi_read(addr, len, 1);
        end

`ifdef AXI_LINE_RESPONDER_DECERR_EN
        // Out-of-range accesses: DECERR and no memory update.
        axi_read(MEM_BYTES, 1, 0);
        wd = new[2]; ws = new[2];
        for (int i = 0; i < 2; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        axi_write(MEM_BYTES, 1, wd, ws, 1);
        axi_read(64'h0, 1, 0);
`endif

        // Mid-burst reset with write in W_DATA and read in R_BURST.
        aw_valid_i = 1'b1; aw_addr_i = 64'h300; aw_len_i = 8'd3; aw_id_i = 4'h5;
        tick();
        aw_valid_i = 1'b0;
        ar_valid_i = 1'b1; ar_addr_i = 64'h40; ar_len_i = 8'd7; ar_id_i = 4'h3;
        tick();
        ar_valid_i = 1'b0;
        for (int k = 0; k < 40 && !r_valid_o; k++) tick();
        check("abort_r_valid_pre", 64'(r_valid_o), 64'd1);
        check("abort_w_ready_pre", 64'(w_ready_o), 64'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_idle("abort");
        tick();
        check_idle("abort_settled");

        // Recovery after abort.
        wd = new[2]; ws = new[2];
        for (int i = 0; i < 2; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        axi_write(64'h80, 1, wd, ws, 1);
        axi_read(64'h80, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
